regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_clear_fsm.sv | 68 ++++++
 rtl/regfile_mp.sv | 84 ++++++++
 tb/tb_regfile_mp.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default constants for the multi-port register file.
//   clr_state_t       - clear sequencer states (IDLE, CLEAR)
//   DEF_*             - default parameter values used by regfile_mp
package regfile_pkg;

    typedef enum logic {
        IDLE,
        CLEAR
    } clr_state_t;

    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_ADDRESS_WIDTH = 5;
    localparam int DEF_NUM_READ      = 2;
    localparam int DEF_TAP_REG       = 10;
    localparam int DEF_BYPASS        = 1;

endpackage

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm: sequencer that zeroes registers 1..DEPTH-1, one per cycle.
//   clk, rst     - clock, synchronous active-high reset
//   i_clr_req    - start a clear (ignored while one is running)
//   o_busy       - clear in progress
//   o_clr_done   - one-cycle pulse during the last clear cycle
//   o_clr_we     - write-zero enable for register o_ptr
//   o_ptr        - register being cleared this cycle
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr_req,
    output logic                     o_busy,
    output logic                     o_clr_done,
    output logic                     o_clr_we,
    output logic [ADDRESS_WIDTH-1:0] o_ptr
);

    localparam logic [ADDRESS_WIDTH-1:0] ONE  = ADDRESS_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH-1:0] LAST = '1;

    clr_state_t                 r_state;
    logic [ADDRESS_WIDTH-1:0]   r_ptr;
    logic                       r_busy;
    logic                       r_done;

    // clr_done is registered, so it is raised on the edge that moves ptr onto LAST.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_clr_req) begin
                        r_state <= CLEAR;
                        r_ptr   <= ONE;
                        r_busy  <= 1'b1;
                        r_done  <= (ONE == LAST);
                    end
                end
                CLEAR: begin
                    r_ptr <= r_ptr + ONE;
                    if (r_ptr == LAST) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else begin
                        r_done  <= (r_ptr + ONE == LAST);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_clr_done = r_done;
    assign o_clr_we   = r_busy;
    assign o_ptr      = r_ptr;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: register file with NUM_READ combinational read ports, one write port,
// optional write-to-read forwarding, a bulk clear sequencer and a tap mirror.
//   clk, rst   - clock, synchronous active-high reset
//   AD / RD    - packed read addresses / read data, port i uses slice i
//   AD3/WE3/WD3 - write address / request / data (dropped while busy)
//   clr_req    - start clearing registers 1..DEPTH-1
//   busy       - clear in progress
//   clr_done   - pulse on the last clear cycle
//   A0         - registered copy of register TAP_REG
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int NUM_READ      = DEF_NUM_READ,
    parameter int TAP_REG       = DEF_TAP_REG,
    parameter int BYPASS        = DEF_BYPASS
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_READ*ADDRESS_WIDTH-1:0] AD,
    output logic [NUM_READ*DATA_WIDTH-1:0]    RD,
    input  logic [ADDRESS_WIDTH-1:0]          AD3,
    input  logic                              WE3,
    input  logic [DATA_WIDTH-1:0]             WD3,
    input  logic                              clr_req,
    output logic                              busy,
    output logic                              clr_done,
    output logic [DATA_WIDTH-1:0]             A0
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] TAP = ADDRESS_WIDTH'(TAP_REG);

    logic [DATA_WIDTH-1:0]    r_mem [DEPTH];
    logic [DATA_WIDTH-1:0]    r_a0;
    logic                     w_clr_we;
    logic [ADDRESS_WIDTH-1:0] w_ptr;
    logic                     w_wr;
    logic [DATA_WIDTH-1:0]    w_tap_next;

    regfile_clear_fsm #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_clear (
        .clk        (clk),
        .rst        (rst),
        .i_clr_req  (clr_req),
        .o_busy     (busy),
        .o_clr_done (clr_done),
        .o_clr_we   (w_clr_we),
        .o_ptr      (w_ptr)
    );

    // Accepted write: excludes address 0 so it can never forward or be stored.
    assign w_wr = WE3 && !busy && (AD3 != '0);

    // Value register TAP will hold after this edge, so A0 never lags the array.
    always_comb begin
        w_tap_next = (w_clr_we && w_ptr == TAP) ? '0 :
                     (w_wr && AD3 == TAP)       ? WD3 : r_mem[TAP];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
            r_a0 <= '0;
        end else begin
            if (w_wr) r_mem[AD3] <= WD3;
            if (w_clr_we) r_mem[w_ptr] <= '0;
            r_a0 <= w_tap_next;
        end
    end

    assign A0 = r_a0;

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] w_addr;
        assign w_addr = AD[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign RD[i*DATA_WIDTH +: DATA_WIDTH] =
            (w_addr == '0)                          ? '0  :
            (BYPASS != 0 && w_wr && w_addr == AD3)  ? WD3 : r_mem[w_addr];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp, one DUT with forwarding and one without.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst, we3, clr_req;
    logic [9:0]  ad;
    logic [4:0]  ad3;
    logic [31:0] wd3;
    logic [63:0] rd_b, rd_n;
    logic        busy_b, busy_n, done_b, done_n;
    logic [31:0] a0_b, a0_n;

    logic [31:0] ref_mem [32];
    logic [31:0] q [$];
    logic [31:0] e;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    regfile_mp #(.BYPASS(1)) dut (
        .clk(clk), .rst(rst), .AD(ad), .RD(rd_b), .AD3(ad3), .WE3(we3), .WD3(wd3),
        .clr_req(clr_req), .busy(busy_b), .clr_done(done_b), .A0(a0_b)
    );

    regfile_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .AD(ad), .RD(rd_n), .AD3(ad3), .WE3(we3), .WD3(wd3),
        .clr_req(clr_req), .busy(busy_n), .clr_done(done_n), .A0(a0_n)
    );

    function automatic logic [31:0] fillv(input int a);
        return 32'hA500_0000 + a * 32'h0001_0003;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; we3 = 1'b0; clr_req = 1'b0; ad = '0; ad3 = '0; wd3 = '0;
        tick();
        rst = 1'b0;
        for (int a = 0; a < 32; a++) ref_mem[a] = 32'h0;
        for (int a = 0; a < 32; a++) begin
            ad = {a[4:0], a[4:0]};
            q.push_back(ref_mem[a]); q.push_back(ref_mem[a]); q.push_back(ref_mem[a]);
            #1;
            e = q.pop_front(); n_cmp++;
            if (rd_b[31:0] !== e) begin n_err++; $display("FAIL reset_rd0 a=%0d got=%h exp=%h", a, rd_b[31:0], e); end
            e = q.pop_front(); n_cmp++;
            if (rd_b[63:32] !== e) begin n_err++; $display("FAIL reset_rd1 a=%0d got=%h exp=%h", a, rd_b[63:32], e); end
            e = q.pop_front(); n_cmp++;
            if (rd_n[31:0] !== e) begin n_err++; $display("FAIL reset_nb_rd0 a=%0d got=%h exp=%h", a, rd_n[31:0], e); end
        end
        q.push_back(32'h0);
        e = q.pop_front(); n_cmp++;
        if (a0_b !== e) begin n_err++; $display("FAIL reset_a0 got=%h exp=%h", a0_b, e); end
        n_cmp++;
        if (busy_b !== 1'b0 || done_b !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b/%b exp=0/0", busy_b, done_b); end
    endtask

    task automatic test_bypass();
        tick();
        ad = {5'd0, 5'd5}; ad3 = 5'd5; wd3 = 32'hDEAD_BEEF; we3 = 1'b1;
        q.push_back(32'hDEAD_BEEF); q.push_back(ref_mem[5]);
        #2;
        e = q.pop_front(); n_cmp++;
        if (rd_b[31:0] !== e) begin n_err++; $display("FAIL bypass_same_cycle got=%h exp=%h", rd_b[31:0], e); end
        e = q.pop_front(); n_cmp++;
        if (rd_n[31:0] !== e) begin n_err++; $display("FAIL nobypass_same_cycle got=%h exp=%h", rd_n[31:0], e); end
        ref_mem[5] = 32'hDEAD_BEEF;
        tick();
        we3 = 1'b0;
        q.push_back(ref_mem[5]); q.push_back(ref_mem[5]);
        #2;
        e = q.pop_front(); n_cmp++;
        if (rd_b[31:0] !== e) begin n_err++; $display("FAIL bypass_next_cycle got=%h exp=%h", rd_b[31:0], e); end
        e = q.pop_front(); n_cmp++;
        if (rd_n[31:0] !== e) begin n_err++; $display("FAIL nobypass_next_cycle got=%h exp=%h", rd_n[31:0], e); end
    endtask

    task automatic test_x0_tap();
        tick();
        we3 = 1'b1; ad3 = 5'd0; wd3 = 32'h1234; ad = '0;
        q.push_back(32'h0);
        #2;
        e = q.pop_front(); n_cmp++;
        if (rd_b[31:0] !== e) begin n_err++; $display("FAIL x0_fwd got=%h exp=%h", rd_b[31:0], e); end
        tick();
        we3 = 1'b0;
        q.push_back(32'h0); q.push_back(32'h0);
        #2;
        e = q.pop_front(); n_cmp++;
        if (rd_b[31:0] !== e) begin n_err++; $display("FAIL x0_read got=%h exp=%h", rd_b[31:0], e); end
        e = q.pop_front(); n_cmp++;
        if (rd_n[63:32] !== e) begin n_err++; $display("FAIL x0_read_nb got=%h exp=%h", rd_n[63:32], e); end
        tick();
        we3 = 1'b1; ad3 = 5'd10; wd3 = 32'h55;
        q.push_back(ref_mem[10]);
        #2;
        e = q.pop_front(); n_cmp++;
        if (a0_b !== e) begin n_err++; $display("FAIL a0_before got=%h exp=%h", a0_b, e); end
        ref_mem[10] = 32'h55;
        tick();
        we3 = 1'b0;
        q.push_back(ref_mem[10]); q.push_back(ref_mem[10]);
        #2;
        e = q.pop_front(); n_cmp++;
        if (a0_b !== e) begin n_err++; $display("FAIL a0_after got=%h exp=%h", a0_b, e); end
        e = q.pop_front(); n_cmp++;
        if (a0_n !== e) begin n_err++; $display("FAIL a0_after_nb got=%h exp=%h", a0_n, e); end
    endtask

    task automatic test_clear();
        int p1;
        for (int a = 1; a < 32; a++) begin
            tick();
            we3 = 1'b1; ad3 = a[4:0]; wd3 = fillv(a);
            ref_mem[a] = fillv(a);
        end
        tick();
        we3 = 1'b0; clr_req = 1'b1;
        q.push_back(ref_mem[10]);
        #2;
        e = q.pop_front(); n_cmp++;
        if (a0_b !== e) begin n_err++; $display("FAIL fill_a0 got=%h exp=%h", a0_b, e); end
        tick();
        for (int c = 1; c <= 31; c++) begin
            p1 = (c == 5) ? 3 : c - 1;
            ad = {p1[4:0], c[4:0]};
            we3 = (c == 5); ad3 = 5'd3; wd3 = 32'h77;
            clr_req = (c == 2);
            q.push_back(ref_mem[c]); q.push_back(ref_mem[p1]); q.push_back(ref_mem[10]);
            #2;
            n_cmp++;
            if (busy_b !== 1'b1 || done_b !== (c == 31)) begin
                n_err++; $display("FAIL clear_status c=%0d got=%b/%b exp=1/%b", c, busy_b, done_b, c == 31);
            end
            e = q.pop_front(); n_cmp++;
            if (rd_b[31:0] !== e) begin n_err++; $display("FAIL clear_rd0 c=%0d got=%h exp=%h", c, rd_b[31:0], e); end
            e = q.pop_front(); n_cmp++;
            if (rd_b[63:32] !== e) begin n_err++; $display("FAIL clear_rd1 c=%0d got=%h exp=%h", c, rd_b[63:32], e); end
            e = q.pop_front(); n_cmp++;
            if (a0_b !== e) begin n_err++; $display("FAIL clear_a0 c=%0d got=%h exp=%h", c, a0_b, e); end
            ref_mem[c] = 32'h0;
            tick();
        end
        we3 = 1'b0; clr_req = 1'b0;
        #2;
        n_cmp++;
        if (busy_b !== 1'b0 || done_b !== 1'b0) begin n_err++; $display("FAIL clear_end got=%b/%b exp=0/0", busy_b, done_b); end
        for (int a = 0; a < 32; a++) begin
            ad = {a[4:0], a[4:0]};
            q.push_back(ref_mem[a]); q.push_back(ref_mem[a]);
            #1;
            e = q.pop_front(); n_cmp++;
            if (rd_b[31:0] !== e) begin n_err++; $display("FAIL cleared_rd0 a=%0d got=%h exp=%h", a, rd_b[31:0], e); end
            e = q.pop_front(); n_cmp++;
            if (rd_n[63:32] !== e) begin n_err++; $display("FAIL cleared_nb_rd1 a=%0d got=%h exp=%h", a, rd_n[63:32], e); end
        end
    endtask

    task automatic test_clr_write_same();
        tick();
        we3 = 1'b1; ad3 = 5'd31; wd3 = 32'hAA; clr_req = 1'b1; ad = {5'd0, 5'd31};
        ref_mem[31] = 32'hAA;
        tick();
        we3 = 1'b0; clr_req = 1'b0;
        for (int c = 1; c <= 31; c++) begin
            q.push_back(ref_mem[31]);
            #2;
            e = q.pop_front(); n_cmp++;
            if (rd_b[31:0] !== e || busy_b !== 1'b1) begin
                n_err++; $display("FAIL same_cycle_x31 c=%0d got=%h busy=%b exp=%h busy=1", c, rd_b[31:0], busy_b, e);
            end
            ref_mem[c] = 32'h0;
            tick();
        end
        q.push_back(ref_mem[31]);
        #2;
        e = q.pop_front(); n_cmp++;
        if (rd_b[31:0] !== e || busy_b !== 1'b0) begin
            n_err++; $display("FAIL same_cycle_end got=%h busy=%b exp=%h busy=0", rd_b[31:0], busy_b, e);
        end
    endtask

    task automatic test_reset_mid_clear();
        tick(); we3 = 1'b1; ad3 = 5'd7;  wd3 = 32'h1111;
        tick(); ad3 = 5'd10; wd3 = 32'h2222;
        tick(); ad3 = 5'd20; wd3 = 32'h3333;
        tick(); we3 = 1'b0; clr_req = 1'b1;
        tick(); clr_req = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        #2;
        n_cmp++;
        if (busy_b !== 1'b1) begin n_err++; $display("FAIL midclear_busy got=%b exp=1", busy_b); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int a = 0; a < 32; a++) ref_mem[a] = 32'h0;
        ad = {5'd7, 5'd20};
        q.push_back(ref_mem[20]); q.push_back(ref_mem[7]); q.push_back(ref_mem[10]);
        #2;
        n_cmp++;
        if (busy_b !== 1'b0 || done_b !== 1'b0) begin n_err++; $display("FAIL rst_abort got=%b/%b exp=0/0", busy_b, done_b); end
        e = q.pop_front(); n_cmp++;
        if (rd_b[31:0] !== e) begin n_err++; $display("FAIL rst_x20 got=%h exp=%h", rd_b[31:0], e); end
        e = q.pop_front(); n_cmp++;
        if (rd_b[63:32] !== e) begin n_err++; $display("FAIL rst_x7 got=%h exp=%h", rd_b[63:32], e); end
        e = q.pop_front(); n_cmp++;
        if (a0_b !== e) begin n_err++; $display("FAIL rst_a0 got=%h exp=%h", a0_b, e); end
        tick();
        we3 = 1'b1; ad3 = 5'd9; wd3 = 32'h99; ad = {5'd0, 5'd0};
        ref_mem[9] = 32'h99;
        tick();
        we3 = 1'b0; ad = {5'd0, 5'd9};
        q.push_back(ref_mem[9]);
        #2;
        e = q.pop_front(); n_cmp++;
        if (rd_n[31:0] !== e || busy_b !== 1'b0) begin
            n_err++; $display("FAIL post_rst_write got=%h busy=%b exp=%h busy=0", rd_n[31:0], busy_b, e);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_x0_tap();
        test_clear();
        test_clr_write_same();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
